// File: rtl/led_breathe.sv
// -----------------------------------------------------------------------------
// led_breathe
//
// LED driver for the two board LEDs. A pushbutton steps through four modes:
// OFF, ON, BREATHE (complementary PWM brightness ramp) and BLINK
// (complementary square wave). All logic runs in the single clk domain.
//
// Ports
//   clk        in   1  PLL output clock
//   reset_n    in   1  asynchronous assert, active-low reset; the release edge
//                      is already synchronized upstream
//   btn_n      in   1  raw pushbutton, active low, asynchronous to clk
//   led0       out  1  LED 0 drive, active high, registered
//   led1       out  1  LED 1 drive, active high, registered
//   dbg_state  out  2  current mode state (OFF=0, ON=1, BREATHE=2, BLINK=3)
//
// Parameters
//   PWM_BITS      PWM counter width; PWM period is 2^PWM_BITS cycles
//   STEP_PERIODS  PWM periods between brightness steps (>= 1)
//   DEBOUNCE_CYC  stable synchronized samples needed to accept a level (>= 2)
//   BLINK_CYC     clk cycles per blink half-period (>= 1)
//
// Latency: btn_n falling -> 2 sync cycles -> DEBOUNCE_CYC cycles to the
// debounced fall (press pulse that cycle) -> state register -> output
// register, i.e. 2 + DEBOUNCE_CYC + 2 cycles.
// -----------------------------------------------------------------------------
module led_breathe #(
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 64,
    parameter int DEBOUNCE_CYC = 65536,
    parameter int BLINK_CYC    = 12500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_n,
    output logic       led0,
    output logic       led1,
    output logic [1:0] dbg_state
);

    // -------------------------------------------------------------------------
    // Derived widths and terminal counts
    // -------------------------------------------------------------------------
    localparam int DB_W    = $clog2(DEBOUNCE_CYC);
    localparam int PER_W   = $clog2(STEP_PERIODS + 1);
    localparam int BLINK_W = $clog2(BLINK_CYC + 1);

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [PER_W-1:0]   PER_LAST   = PER_W'(STEP_PERIODS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

    // duty is one bit wider than the PWM counter so that 2^PWM_BITS (always
    // on) is representable.
    localparam logic [PWM_BITS:0] DUTY_FULL     = {1'b1, {PWM_BITS{1'b0}}};
    localparam logic [PWM_BITS:0] DUTY_FULL_M1  = {1'b0, {PWM_BITS{1'b1}}};
    localparam logic [PWM_BITS:0] DUTY_ONE      = {{PWM_BITS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ON      = 2'd1,
        ST_BREATHE = 2'd2,
        ST_BLINK   = 2'd3
    } mode_t;

    // -------------------------------------------------------------------------
    // Button synchronizer. Both flops reset to the released level so that
    // reset never looks like a press.
    // -------------------------------------------------------------------------
    logic sync_0;
    logic sync_1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_0 <= 1'b1;
            sync_1 <= 1'b1;
        end else begin
            sync_0 <= btn_n;
            sync_1 <= sync_0;
        end
    end

    // -------------------------------------------------------------------------
    // Debouncer. The counter tracks how long the synchronized level has
    // disagreed with the accepted level; any agreement restarts it, so a
    // bounce shorter than DEBOUNCE_CYC samples is discarded. press is
    // registered alongside db, so it is high in the first cycle db reads 0.
    // -------------------------------------------------------------------------
    logic            db;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db     <= 1'b1;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_1 != db) begin
                if (db_cnt == DB_LAST) begin
                    db     <= sync_1;
                    db_cnt <= '0;
                    // Only the 1->0 (press) transition is an event.
                    press  <= ~sync_1;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Mode FSM: state register plus next-state logic. Every press advances
    // OFF -> ON -> BREATHE -> BLINK -> OFF.
    // -------------------------------------------------------------------------
    mode_t state_q;
    mode_t state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BREATHE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (press) begin
            unique case (state_q)
                ST_OFF:     state_d = ST_ON;
                ST_ON:      state_d = ST_BREATHE;
                ST_BREATHE: state_d = ST_BLINK;
                ST_BLINK:   state_d = ST_OFF;
                default:    state_d = ST_BREATHE;
            endcase
        end
    end

    assign dbg_state = state_q;

    // -------------------------------------------------------------------------
    // PWM counter and triangle brightness ramp.
    //
    // duty only moves on the cycle pwm_cnt wraps to 0, so each PWM period is
    // rendered with a single duty value. The direction flag flips when the
    // step lands on an endpoint, which holds each endpoint for exactly one
    // step interval (0,1,..,FULL,FULL-1,..,0,1,..).
    //
    // press has priority over everything here: each mode starts from a
    // known phase, and a step that coincides with the press is dropped.
    // -------------------------------------------------------------------------
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PER_W-1:0]    per_cnt;
    logic [PWM_BITS:0]   duty;
    logic                dir_up;
    logic                pwm_wrap;

    assign pwm_wrap = (pwm_cnt == {PWM_BITS{1'b1}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            per_cnt <= '0;
            duty    <= '0;
            dir_up  <= 1'b1;
        end else if (press) begin
            pwm_cnt <= '0;
            per_cnt <= '0;
            duty    <= '0;
            dir_up  <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_wrap) begin
                if (per_cnt == PER_LAST) begin
                    per_cnt <= '0;
                    if (dir_up) begin
                        duty <= duty + 1'b1;
                        if (duty == DUTY_FULL_M1) begin
                            dir_up <= 1'b0;
                        end
                    end else begin
                        duty <= duty - 1'b1;
                        if (duty == DUTY_ONE) begin
                            dir_up <= 1'b1;
                        end
                    end
                end else begin
                    per_cnt <= per_cnt + 1'b1;
                end
            end
        end
    end

    // led1 mirrors led0 with the complementary duty FULL - duty.
    logic pwm_on;
    logic pwm_on_inv;

    assign pwm_on     = ({1'b0, pwm_cnt} < duty);
    assign pwm_on_inv = ({1'b0, pwm_cnt} < (DUTY_FULL - duty));

    // -------------------------------------------------------------------------
    // Blink generator: blink toggles every BLINK_CYC cycles.
    // -------------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (press) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output stage: decode from the current state, then register.
    // -------------------------------------------------------------------------
    logic led0_d;
    logic led1_d;

    always_comb begin
        led0_d = 1'b0;
        led1_d = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                led0_d = 1'b0;
                led1_d = 1'b0;
            end
            ST_ON: begin
                led0_d = 1'b1;
                led1_d = 1'b1;
            end
            ST_BREATHE: begin
                led0_d = pwm_on;
                led1_d = pwm_on_inv;
            end
            ST_BLINK: begin
                led0_d = blink;
                led1_d = ~blink;
            end
            default: begin
                led0_d = 1'b0;
                led1_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led0 <= 1'b0;
            led1 <= 1'b0;
        end else begin
            led0 <= led0_d;
            led1 <= led1_d;
        end
    end

endmodule

// File: tb/tb_led_breathe.sv
// -----------------------------------------------------------------------------
// tb_led_breathe
//
// Bench for led_breathe with PWM_BITS=3, STEP_PERIODS=1, DEBOUNCE_CYC=4,
// BLINK_CYC=5. Expected LED values come from a closed-form description of
// each mode (triangle duty per 8-cycle period, 5/5 blink, constants), indexed
// by the number of output cycles since the mode started. A button press of
// 4+ cycles applied at a falling clock edge switches the expected mode at
// the 8th following rising edge.
// -----------------------------------------------------------------------------
module tb_led_breathe;

    localparam int PB  = 3;
    localparam int SP  = 1;
    localparam int DC  = 4;
    localparam int BC  = 5;
    localparam int PER = 1 << PB;
    localparam int LAT = 2 + DC + 2;

    localparam int M_OFF     = 0;
    localparam int M_ON      = 1;
    localparam int M_BREATHE = 2;
    localparam int M_BLINK   = 3;

    // ---------------------------------------------------------------- clock
    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_n;
    logic       led0;
    logic       led1;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    led_breathe #(
        .PWM_BITS     (PB),
        .STEP_PERIODS (SP),
        .DEBOUNCE_CYC (DC),
        .BLINK_CYC    (BC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_n     (btn_n),
        .led0      (led0),
        .led1      (led1),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------ scoreboard
    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];

    // Expected-mode tracking
    int mode;
    int k;          // output index within the current mode, for the next edge
    int pend;       // edges left until a pending mode change becomes visible
    int pend_mode;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (mode %0d idx %0d, t=%0t)",
                     name, act, exp, mode, k, $time);
        end
    endtask

    // {led0, led1} for output index kk of mode m.
    function automatic logic [1:0] model(input int m, input int kk);
        int p;
        int pos;
        int d;
        case (m)
            M_OFF: return 2'b00;
            M_ON:  return 2'b11;
            M_BREATHE: begin
                p   = kk / PER;
                pos = kk % PER;
                d   = p % (2 * PER);
                if (d > PER) d = 2 * PER - d;
                return {pos < d, pos < (PER - d)};
            end
            default: return {((kk / BC) % 2) == 1, ((kk / BC) % 2) == 0};
        endcase
    endfunction

    // ---------------------------------------------------------- driver tasks
    // One clock: push the expected value for this rising edge, compare at
    // the following falling edge.
    task automatic step();
        logic [1:0] e;
        @(posedge clk);
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mode = pend_mode;
                k    = 0;
            end
        end
        exp_q.push_back(model(mode, k));
        k++;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty at t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("leds", {led0, led1}, e);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called at a falling edge. Holds the button low for len rising edges.
    task automatic pulse(input int len, input int target);
        btn_n = 1'b0;
        if (len >= DC) begin
            pend      = LAT;
            pend_mode = target;
        end
        run(len);
        btn_n = 1'b1;
    endtask

    // Go to the next mode with a clean press and let it settle.
    task automatic advance(input int target);
        pulse(6, target);
        run(20);
        check("state", dbg_state, 2'(target));
    endtask

    // ------------------------------------------------------- stimulus table
    typedef struct {
        int len;       // cycles btn_n is held low
        int gap;       // cycles observed afterwards
        int exp_mode;  // mode expected once things settle
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{len: 3,   gap: 40,  exp_mode: M_BREATHE};  // bounce: ignored
        vecs[1] = '{len: 10,  gap: 60,  exp_mode: M_BLINK};    // clean press
        vecs[2] = '{len: 100, gap: 20,  exp_mode: M_OFF};      // long hold: one event
        vecs[3] = '{len: 6,   gap: 20,  exp_mode: M_ON};
        vecs[4] = '{len: 6,   gap: 150, exp_mode: M_BREATHE};  // ramp restarts at 0

        btn_n   = 1'b1;
        reset_n = 1'b0;
        mode    = M_BREATHE;
        k       = 0;
        pend    = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_leds", {led0, led1}, 2'b00);
        check("reset_state", dbg_state, 2'(M_BREATHE));

        // Full breathing triangle and into the next rise
        reset_n = 1'b1;
        run(PER * (2 * PER + 2));

        // Table: bounce, press, hold, mode cycle
        for (int i = 0; i < 5; i++) begin
            pulse(vecs[i].len, vecs[i].exp_mode);
            run(vecs[i].gap);
            check("table_state", dbg_state, 2'(vecs[i].exp_mode));
        end

        // Asynchronous reset while both LEDs are lit in ON
        advance(M_BLINK);
        advance(M_OFF);
        advance(M_ON);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_leds", {led0, led1}, 2'b00);
        check("async_reset_state", dbg_state, 2'(M_BREATHE));
        repeat (2) @(negedge clk);
        check("held_reset_leds", {led0, led1}, 2'b00);
        reset_n = 1'b1;
        mode    = M_BREATHE;
        k       = 0;
        pend    = 0;
        run(40);

        // Press clears on the same edge that would step duty: go to ON,
        // then align so the 7th edge after btn_n falls is a pwm_cnt wrap.
        advance(M_BLINK);
        advance(M_OFF);
        advance(M_ON);
        for (int i = 0; i < PER; i++) begin
            if ((k % PER) != 1) step();
        end
        pulse(6, M_BREATHE);
        run(PER * 12);
        check("collision_state", dbg_state, 2'(M_BREATHE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
